seven_seg_mux: RTL and testbench



---
 rtl/seven_seg_mux.sv | 146 ++++++++++++++
 tb/tb_seven_seg_mux.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-frame shadowing
// of the displayed value and optional leading-zero blanking.
module seven_seg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    localparam logic [PW-1:0]         PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    // Active-high glyphs, bit 6 = g .. bit 0 = a
    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g;
        unique case (h)
            4'h0: g = 7'h3f;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5b;
            4'h3: g = 7'h4f;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6d;
            4'h6: g = 7'h7d;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7f;
            4'h9: g = 7'h6f;
            4'ha: g = 7'h77;
            4'hb: g = 7'h7c;
            4'hc: g = 7'h39;
            4'hd: g = 7'h5e;
            4'he: g = 7'h79;
            4'hf: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shv_q, shv_d;
    logic [NUM_DIGITS-1:0]   shdp_q, shdp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    tick;
    logic                    frame;
    logic [3:0]              cur_dig;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    zero_run;

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        shv_d   = shv_q;
        shdp_d  = shdp_q;
        tick    = enable && (presc_q == PRESC_MAX);
        frame   = tick && (idx_q == IDX_MAX);
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            idx_d = frame ? '0 : idx_q + IW'(1);
        end
        // Shadow reload only at the frame boundary keeps a frame coherent
        if (frame) begin
            shv_d  = value;
            shdp_d = dp_in;
        end
        fd_d = frame;
    end

    always_comb begin
        zero_run  = 1'b1;
        cur_dig   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        // Walk from the top digit down so zero_run covers digit i and above
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (shv_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_dig   = shv_q[4*i +: 4];
                cur_dp    = shdp_q[i];
                cur_blank = BLANK_LZ && (i > 0) && zero_run;
            end
        end
    end

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (enable) begin
            an_d  = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
            seg_d = cur_blank ? SEG_OFF
                              : (glyph(cur_dig) ^ {7{SEG_ACTIVE_LOW}});
            dp_d  = cur_dp ^ SEG_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            shv_q   <= '0;
            shdp_q  <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            shv_q   <= shv_d;
            shdp_q  <= shdp_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: three instances cover plain scan,
// leading-zero blanking and the single-digit configuration.
module tb_seven_seg_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;

    logic [15:0] val_a = 16'h1234;
    logic [3:0]  dpi_a = 4'b0000;
    logic [15:0] val_b = 16'h0050;
    logic [3:0]  dpi_b = 4'b1000;
    logic [3:0]  val_c = 4'h0;
    logic        dpi_c = 1'b1;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b;
    logic       an_c;
    logic       fd_a, fd_b, fd_c;

    int errors = 0;
    int checks = 0;

    logic [6:0] gly [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d,
                             7'h7d, 7'h07, 7'h7f, 7'h6f, 7'h77, 7'h7c,
                             7'h39, 7'h5e, 7'h79, 7'h71};

    seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1),
                    .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(val_a),
        .dp_in(dpi_a), .seg(seg_a), .dp(dp_a), .an(an_a),
        .frame_done(fd_a));

    seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1),
                    .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(val_b),
        .dp_in(dpi_b), .seg(seg_b), .dp(dp_b), .an(an_b),
        .frame_done(fd_b));

    seven_seg_mux #(.NUM_DIGITS(1), .REFRESH_DIV(3), .SEG_ACTIVE_LOW(1'b1),
                    .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(val_c),
        .dp_in(dpi_c), .seg(seg_c), .dp(dp_c), .an(an_c),
        .frame_done(fd_c));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_fd(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if ((which == 0 && fd_a) || (which == 1 && fd_b) ||
                (which == 2 && fd_c)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({an_a, seg_a, dp_a, fd_a} !== {4'hf, 7'h7f, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                     an_a, seg_a, dp_a, fd_a);
        end
        checks++;
        if ({an_b, seg_b, dp_b, fd_b} !== {4'hf, 7'h7f, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                     an_b, seg_b, dp_b, fd_b);
        end
        checks++;
        if ({an_c, seg_c, dp_c, fd_c} !== {1'b1, 7'h7f, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_c: got an=%b seg=%b dp=%b fd=%b want 1 1111111 1 0",
                     an_c, seg_c, dp_c, fd_c);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int n;
        logic [15:0] v;
        logic [3:0] ea;
        logic ef;
        v = 16'h1234;
        wait_fd(0, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL scan_wait: got no frame_done want a pulse");
        end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                ea = 4'hf;
                ea[d] = 1'b0;
                ef = (d == 3 && c == 3);
                checks++;
                if ({an_a, seg_a, dp_a, fd_a} !==
                    {ea, ~gly[v[4*d +: 4]], 1'b1, ef}) begin
                    errors++;
                    $display("FAIL scan d%0d c%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=1 fd=%b",
                             d, c, an_a, seg_a, dp_a, fd_a, ea,
                             ~gly[v[4*d +: 4]], ef);
                end
            end
        end
    endtask

    task automatic test_blank();
        int n;
        logic [6:0] es [4];
        logic [3:0] ea;
        es[0] = ~7'h3f;
        es[1] = ~7'h6d;
        es[2] = 7'h7f;
        es[3] = 7'h7f;
        wait_fd(1, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL blank_wait: got no frame_done want a pulse");
        end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                ea = 4'hf;
                ea[d] = 1'b0;
                checks++;
                if ({an_b, seg_b, dp_b} !== {ea, es[d], (d != 3)}) begin
                    errors++;
                    $display("FAIL blank d%0d c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             d, c, an_b, seg_b, dp_b, ea, es[d], (d != 3));
                end
            end
        end
    endtask

    task automatic test_tear();
        int n;
        int d;
        logic [15:0] v;
        logic [3:0] ea;
        logic ef;
        wait_fd(0, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL tear_wait: got no frame_done want a pulse");
        end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            v = (k <= 16) ? 16'h1234 : 16'habcd;
            ea = 4'hf;
            ea[d] = 1'b0;
            ef = (k == 16 || k == 32);
            checks++;
            if ({an_a, seg_a, fd_a} !== {ea, ~gly[v[4*d +: 4]], ef}) begin
                errors++;
                $display("FAIL tear k%0d: got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         k, an_a, seg_a, fd_a, ea, ~gly[v[4*d +: 4]], ef);
            end
            if (k == 6) val_a = 16'habcd;
        end
    endtask

    task automatic test_enable();
        int n;
        int d;
        logic [15:0] v;
        logic [3:0] ea;
        logic ef;
        v = 16'habcd;
        wait_fd(0, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL en_wait: got no frame_done want a pulse");
        end
        repeat (6) @(negedge clk);
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if ({an_a, seg_a, dp_a, fd_a} !== {4'hf, 7'h7f, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL en_off k%0d: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                         k, an_a, seg_a, dp_a, fd_a);
            end
        end
        enable = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            d = (j <= 2) ? 1 : (j <= 6) ? 2 : 3;
            ea = 4'hf;
            ea[d] = 1'b0;
            ef = (j == 10);
            checks++;
            if ({an_a, seg_a, fd_a} !== {ea, ~gly[v[4*d +: 4]], ef}) begin
                errors++;
                $display("FAIL en_resume j%0d: got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         j, an_a, seg_a, fd_a, ea, ~gly[v[4*d +: 4]], ef);
            end
        end
    endtask

    task automatic test_async_reset();
        int d;
        logic [3:0] ea;
        logic [6:0] eb;
        logic ef;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an_a, seg_a, dp_a, fd_a, an_b} !==
            {4'hf, 7'h7f, 1'b1, 1'b0, 4'hf}) begin
            errors++;
            $display("FAIL arst_now: got an=%b seg=%b dp=%b fd=%b anb=%b want 1111 1111111 1 0 1111",
                     an_a, seg_a, dp_a, fd_a, an_b);
        end
        @(negedge clk);
        checks++;
        if ({an_a, seg_a, fd_a} !== {4'hf, 7'h7f, 1'b0}) begin
            errors++;
            $display("FAIL arst_hold: got an=%b seg=%b fd=%b want 1111 1111111 0",
                     an_a, seg_a, fd_a);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            d = (k - 1) / 4;
            ea = 4'hf;
            ea[d] = 1'b0;
            ef = (k == 16);
            eb = (d == 0) ? ~7'h3f : 7'h7f;
            checks++;
            if ({an_a, seg_a, fd_a, an_b, seg_b} !==
                {ea, ~gly[0], ef, ea, eb}) begin
                errors++;
                $display("FAIL arst_frame k%0d: got an=%b seg=%b fd=%b anb=%b segb=%b want an=%b seg=%b fd=%b segb=%b",
                         k, an_a, seg_a, fd_a, an_b, seg_b, ea, ~gly[0],
                         ef, eb);
            end
        end
    endtask

    task automatic test_single_digit();
        int n;
        for (int v = 0; v < 16; v++) begin
            val_c = 4'(v);
            wait_fd(2, n);
            checks++;
            if (n < 0 || (v > 0 && n != 2)) begin
                errors++;
                $display("FAIL n1_period v%0d: got %0d cycles want 2 (3-cycle frame)",
                         v, n);
            end
            @(negedge clk);
            checks++;
            if ({an_c, seg_c, dp_c} !== {1'b0, ~gly[v], 1'b0}) begin
                errors++;
                $display("FAIL n1_glyph v%0d: got an=%b seg=%b dp=%b want an=0 seg=%b dp=0",
                         v, an_c, seg_c, dp_c, ~gly[v]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_tear();
        test_enable();
        test_async_reset();
        test_single_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
